// File: rtl/mem_morpher_arbiter_if.sv
// Request/response/morpher bus shared by the mem_morpher_arbiter and its requesters.
// The slave modport is the arbiter side; the master modport is the requester/morpher side.
interface mem_morpher_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 256
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      mm_valid;
  logic [ADDR_W-1:0]         mm_addr;
  logic [DATA_W-1:0]         mm_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready, mm_data,
    output req_ready, rsp_valid, rsp_data, mm_valid, mm_addr
  );

  modport master (
    output req_valid, req_addr, rsp_ready, mm_data,
    input  req_ready, rsp_valid, rsp_data, mm_valid, mm_addr
  );
endinterface

// File: rtl/mem_morpher_arbiter.sv
// Round-robin arbiter sharing one memory-morpher read port between NUM_REQ requesters.
// Optional grant/stall performance counters are enabled by defining MEM_MORPHER_ARB_PERF_EN.
module mem_morpher_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 256
) (
  input  logic                      clock,
  input  logic                      reset,
  mem_morpher_arbiter_if.slave      bus,
  output logic                      busy
`ifdef MEM_MORPHER_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]     perf_grants,
  output logic [31:0]               perf_stall
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [ADDR_W-1:0]  r_mm_addr;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               w_grant_found;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [NUM_REQ-1:0] w_rsp_valid;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [PTR_W-1:0]   w_ptr_nxt;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  // Round-robin search: first valid requester at or after r_rr_ptr.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant_found && bus.req_valid[wrap_idx(r_rr_ptr, k)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = wrap_idx(r_rr_ptr, k);
      end else begin
        w_grant_found = w_grant_found;
      end
    end
  end

  assign w_sel_addr = bus.req_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_ptr_nxt  = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);

  // Next-state and grant; a RESP handshake may grant directly (back-to-back path).
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_found) begin
          w_accept                 = 1'b1;
          w_req_ready[w_grant_idx] = 1'b1;
          w_state_nxt              = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready[r_owner] && w_grant_found) begin
          w_accept                 = 1'b1;
          w_req_ready[w_grant_idx] = 1'b1;
          w_state_nxt              = S_ISSUE;
        end else if (bus.rsp_ready[r_owner]) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, grant bookkeeping and line capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_mm_addr  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner   <= w_grant_idx;
        r_rr_ptr  <= w_ptr_nxt;
        r_mm_addr <= {w_sel_addr[ADDR_W-1:5], 5'b00000};
      end else begin
        r_owner   <= r_owner;
        r_rr_ptr  <= r_rr_ptr;
        r_mm_addr <= r_mm_addr;
      end
      if (r_state == S_ISSUE) begin
        r_rsp_data <= bus.mm_data;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
    end
  end

  // Response valid is one-hot to the owner while in RESP.
  always_comb begin
    w_rsp_valid = '0;
    if (r_state == S_RESP) begin
      w_rsp_valid[r_owner] = 1'b1;
    end else begin
      w_rsp_valid = '0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.mm_valid  = (r_state == S_ISSUE);
  assign bus.mm_addr   = r_mm_addr;
  assign busy          = (r_state != S_IDLE);

`ifdef MEM_MORPHER_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] r_perf_grants;
  logic [31:0]           r_perf_stall;

  // Wrapping per-requester grant counters and a saturating stall counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_grants <= '0;
      r_perf_stall  <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_req_ready[i]) begin
          r_perf_grants[i*32 +: 32] <= r_perf_grants[i*32 +: 32] + 32'd1;
        end else begin
          r_perf_grants[i*32 +: 32] <= r_perf_grants[i*32 +: 32];
        end
      end
      if ((|bus.req_valid) && (w_req_ready == '0) && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_morpher_arbiter.sv
// Directed, table-driven bench for mem_morpher_arbiter: one record per clock cycle,
// plus hand-written sequences for reset state and asynchronous reset during RESP.
module tb_mem_morpher_arbiter;

  localparam logic [63:0] P  = 64'h0000_0000_8000_0047;
  localparam logic [63:0] PA = 64'h0000_0000_8000_0040;
  localparam logic [63:0] X  = 64'h0000_0000_1000_0013;
  localparam logic [63:0] XA = 64'h0000_0000_1000_0000;
  localparam logic [63:0] Y  = 64'h0000_0000_2000_002F;
  localparam logic [63:0] YA = 64'h0000_0000_2000_0020;

  typedef struct {
    logic [1:0]  rv;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [1:0]  rr;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rsp;
    logic        e_mm;
    logic        e_busy;
    logic [63:0] e_addr;
    logic [63:0] e_daddr;
  } vec_t;

  logic clock;
  logic reset;
  logic busy;
  int   n_checks;
  int   n_err;
  vec_t tbl [24];

  mem_morpher_arbiter_if #(.NUM_REQ(2), .ADDR_W(64), .DATA_W(256)) bus ();

`ifdef MEM_MORPHER_ARB_PERF_EN
  logic [63:0] perf_grants;
  logic [31:0] perf_stall;
  mem_morpher_arbiter #(.NUM_REQ(2), .ADDR_W(64), .DATA_W(256)) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy),
    .perf_grants(perf_grants), .perf_stall(perf_stall)
  );
`else
  mem_morpher_arbiter #(.NUM_REQ(2), .ADDR_W(64), .DATA_W(256)) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy)
  );
`endif

  // Morpher model: line content is a fixed function of the line address.
  function automatic logic [255:0] line_of(input logic [63:0] a);
    return {a ^ 64'h0123_4567_89AB_CDEF, ~a, a + 64'd1, a};
  endfunction

  assign bus.mm_data = line_of(bus.mm_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_v(input int i, input logic [1:0] rv, input logic [63:0] a0,
                       input logic [1:0] rr, input logic [1:0] e_rdy, input logic [1:0] e_rsp,
                       input logic e_mm, input logic e_busy, input logic [63:0] e_addr,
                       input logic [63:0] e_daddr);
    tbl[i].rv = rv;       tbl[i].a0 = a0;         tbl[i].a1 = Y;
    tbl[i].rr = rr;       tbl[i].e_rdy = e_rdy;   tbl[i].e_rsp = e_rsp;
    tbl[i].e_mm = e_mm;   tbl[i].e_busy = e_busy; tbl[i].e_addr = e_addr;
    tbl[i].e_daddr = e_daddr;
  endtask

  task automatic run_vec(input int i);
    bus.req_valid = tbl[i].rv;
    bus.req_addr  = {tbl[i].a1, tbl[i].a0};
    bus.rsp_ready = tbl[i].rr;
    #2;
    chk($sformatf("v%0d_req_ready", i), 256'(bus.req_ready), 256'(tbl[i].e_rdy));
    chk($sformatf("v%0d_rsp_valid", i), 256'(bus.rsp_valid), 256'(tbl[i].e_rsp));
    chk($sformatf("v%0d_mm_valid", i), 256'(bus.mm_valid), 256'(tbl[i].e_mm));
    chk($sformatf("v%0d_busy", i), 256'(busy), 256'(tbl[i].e_busy));
    chk($sformatf("v%0d_mm_addr", i), 256'(bus.mm_addr), 256'(tbl[i].e_addr));
    if (tbl[i].e_rsp != 2'b00) begin
      chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, line_of(tbl[i].e_daddr));
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    //      i   rv     a0  rr     rdy    rsp    mm    busy  mm_addr     data addr
    set_v(  0, 2'b01, P,  2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 64'd0, 64'd0);
    set_v(  1, 2'b00, P,  2'b00, 2'b00, 2'b00, 1'b1, 1'b1, PA,    64'd0);
    set_v(  2, 2'b00, P,  2'b00, 2'b00, 2'b01, 1'b0, 1'b1, PA,    PA);
    set_v(  3, 2'b00, P,  2'b01, 2'b00, 2'b01, 1'b0, 1'b1, PA,    PA);
    set_v(  4, 2'b00, X,  2'b00, 2'b00, 2'b00, 1'b0, 1'b0, PA,    64'd0);
    set_v(  5, 2'b11, X,  2'b11, 2'b10, 2'b00, 1'b0, 1'b0, PA,    64'd0);
    set_v(  6, 2'b11, X,  2'b11, 2'b00, 2'b00, 1'b1, 1'b1, YA,    64'd0);
    set_v(  7, 2'b11, X,  2'b11, 2'b01, 2'b10, 1'b0, 1'b1, YA,    YA);
    set_v(  8, 2'b11, X,  2'b11, 2'b00, 2'b00, 1'b1, 1'b1, XA,    64'd0);
    set_v(  9, 2'b11, X,  2'b11, 2'b10, 2'b01, 1'b0, 1'b1, XA,    XA);
    set_v( 10, 2'b11, X,  2'b11, 2'b00, 2'b00, 1'b1, 1'b1, YA,    64'd0);
    set_v( 11, 2'b11, X,  2'b11, 2'b01, 2'b10, 1'b0, 1'b1, YA,    YA);
    set_v( 12, 2'b00, X,  2'b00, 2'b00, 2'b00, 1'b1, 1'b1, XA,    64'd0);
    for (int k = 13; k <= 17; k++) begin
      set_v(k, 2'b11, X, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1, XA, XA);
    end
    set_v( 18, 2'b01, X,  2'b01, 2'b01, 2'b01, 1'b0, 1'b1, XA,    XA);
    set_v( 19, 2'b00, X,  2'b00, 2'b00, 2'b00, 1'b1, 1'b1, XA,    64'd0);
    set_v( 20, 2'b00, X,  2'b00, 2'b00, 2'b01, 1'b0, 1'b1, XA,    XA);
    set_v( 21, 2'b11, X,  2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 64'd0, 64'd0);
    set_v( 22, 2'b11, X,  2'b11, 2'b00, 2'b00, 1'b1, 1'b1, XA,    64'd0);
    set_v( 23, 2'b11, X,  2'b11, 2'b10, 2'b01, 1'b0, 1'b1, XA,    XA);

    reset         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    bus.rsp_ready = 2'b00;
    #2;
    chk("rst_req_ready", 256'(bus.req_ready), 256'(2'b00));
    chk("rst_rsp_valid", 256'(bus.rsp_valid), 256'(2'b00));
    chk("rst_mm_valid", 256'(bus.mm_valid), 256'(1'b0));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_mm_addr", 256'(bus.mm_addr), 256'(64'd0));
    chk("rst_rsp_data", bus.rsp_data, 256'd0);
    #5 reset = 1'b1;

    @(posedge clock);
    #1;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      run_vec(i);
    end

`ifdef MEM_MORPHER_ARB_PERF_EN
    chk("perf_grants", 256'(perf_grants), 256'({32'd2, 32'd4}));
    chk("perf_stall", 256'(perf_stall), 256'(32'd8));
`endif

    // Asynchronous reset while a response is pending, between clock edges.
    #1 reset = 1'b0;
    #1;
    chk("arst_rsp_valid", 256'(bus.rsp_valid), 256'(2'b00));
    chk("arst_mm_valid", 256'(bus.mm_valid), 256'(1'b0));
    chk("arst_busy", 256'(busy), 256'(1'b0));
    chk("arst_rsp_data", bus.rsp_data, 256'd0);
`ifdef MEM_MORPHER_ARB_PERF_EN
    chk("arst_perf_grants", 256'(perf_grants), 256'd0);
    chk("arst_perf_stall", 256'(perf_stall), 256'd0);
`endif
    #1 reset = 1'b1;

    for (int i = 21; i <= 23; i++) begin
      @(posedge clock);
      #1;
      run_vec(i);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
